// File: rtl/bank_cmd_scheduler_if.sv
// Request/command bus between the request front end, the scheduler and command_sender.
//   master : front end; drives req_* and observes the scheduler outputs
//   slave  : scheduler; samples req_* and drives ready/command/status outputs
// Signals:
//   req_valid_in/req_ready_out          request handshake
//   req_write_in, req_paddr_in          request kind and physical address
//   req_wdata_in                        512-bit write line
//   cmd_out/cmd_valid_out               DDR4 command (RD 0, WR 1, ACT 2, PRE 3, NOP 7)
//   bg_out/ba_out/row_out/col_out       command target
//   wdata_out                           latched write line
//   done_out/busy_out                   completion pulse / request in flight
interface bank_cmd_scheduler_if #(
  parameter int unsigned BANK_GROUPS     = 4,
  parameter int unsigned BANKS_PER_GROUP = 2,
  parameter int unsigned ROW_BITS        = 8,
  parameter int unsigned COL_BITS        = 4,
  parameter int unsigned PADDR_BITS      = 64
);
  localparam int unsigned BgW = $clog2(BANK_GROUPS);
  localparam int unsigned BaW = $clog2(BANKS_PER_GROUP);

  logic                  req_valid_in;
  logic                  req_ready_out;
  logic                  req_write_in;
  logic [PADDR_BITS-1:0] req_paddr_in;
  logic [511:0]          req_wdata_in;
  logic [2:0]            cmd_out;
  logic                  cmd_valid_out;
  logic [BgW-1:0]        bg_out;
  logic [BaW-1:0]        ba_out;
  logic [ROW_BITS-1:0]   row_out;
  logic [COL_BITS-1:0]   col_out;
  logic [511:0]          wdata_out;
  logic                  done_out;
  logic                  busy_out;

  modport master (
    output req_valid_in, req_write_in, req_paddr_in, req_wdata_in,
    input  req_ready_out, cmd_out, cmd_valid_out, bg_out, ba_out, row_out, col_out,
    input  wdata_out, done_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_write_in, req_paddr_in, req_wdata_in,
    output req_ready_out, cmd_out, cmd_valid_out, bg_out, ba_out, row_out, col_out,
    output wdata_out, done_out, busy_out
  );
endinterface

// File: rtl/bank_cmd_scheduler.sv
// In-order, single-outstanding DDR4 command sequencer with open-page policy.
// Accepts one request at a time, tracks the open row of every bank and issues
// PRE/ACT/RD/WR with the precharge, activation and CAS/burst gaps enforced.
// Ports:
//   clk_in    clock, all state on posedge
//   rst_N_in  asynchronous active-low reset
//   bus       slave side of bank_cmd_scheduler_if (request in, command/status out)
module bank_cmd_scheduler #(
  parameter int unsigned CAS_LATENCY        = 22,
  parameter int unsigned ACTIVATION_LATENCY = 8,
  parameter int unsigned PRECHARGE_LATENCY  = 5,
  parameter int unsigned BURST_LEN          = 8,
  parameter int unsigned BANK_GROUPS        = 4,
  parameter int unsigned BANKS_PER_GROUP    = 2,
  parameter int unsigned ROW_BITS           = 8,
  parameter int unsigned COL_BITS           = 4,
  parameter int unsigned PADDR_BITS         = 64
) (
  input logic                  clk_in,
  input logic                  rst_N_in,
  bank_cmd_scheduler_if.slave  bus
);
  localparam int unsigned BgW      = $clog2(BANK_GROUPS);
  localparam int unsigned BaW      = $clog2(BANKS_PER_GROUP);
  localparam int unsigned BankW    = BgW + BaW;
  localparam int unsigned NumSlots = 1 << BankW;
  localparam int unsigned AddrHi   = COL_BITS + BankW + ROW_BITS;
  localparam int unsigned CntW     = $clog2(CAS_LATENCY + BURST_LEN) + 1;

  localparam logic [CntW-1:0] PreLoad = CntW'(PRECHARGE_LATENCY - 1);
  localparam logic [CntW-1:0] ActLoad = CntW'(ACTIVATION_LATENCY - 1);
  localparam logic [CntW-1:0] RdLoad  = CntW'(CAS_LATENCY + BURST_LEN - 1);
  localparam logic [CntW-1:0] WrLoad  = CntW'(BURST_LEN - 1);

  localparam logic [2:0] CmdRd  = 3'd0;
  localparam logic [2:0] CmdWr  = 3'd1;
  localparam logic [2:0] CmdAct = 3'd2;
  localparam logic [2:0] CmdPre = 3'd3;
  localparam logic [2:0] CmdNop = 3'b111;

  typedef enum logic [2:0] {StIdle, StDecide, StWaitPre, StWaitAct, StXfer} state_e;

  state_e                            state_q, state_d;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic                              write_q;
  logic [BgW-1:0]                    bg_q;
  logic [BaW-1:0]                    ba_q;
  logic [ROW_BITS-1:0]               row_q;
  logic [COL_BITS-1:0]               col_q;
  logic [511:0]                      wdata_q;
  logic [NumSlots-1:0]               open_valid_q;
  logic [NumSlots-1:0][ROW_BITS-1:0] open_row_q;

  logic                              accept, hit, ready, done, cmd_valid;
  logic [2:0]                        cmd;
  logic [BankW-1:0]                  bank_idx;
  logic [CntW-1:0]                   xfer_load;
  logic                              unused_paddr;

  // Upper address bits are beyond the mapped row and carry no meaning here.
  assign unused_paddr = ^bus.req_paddr_in[PADDR_BITS-1:AddrHi];

  assign accept    = bus.req_valid_in & ready;
  assign bank_idx  = {bg_q, ba_q};
  assign hit       = open_valid_q[bank_idx] && (open_row_q[bank_idx] == row_q);
  assign xfer_load = write_q ? WrLoad : RdLoad;

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are held from accept until the next accept.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      write_q <= 1'b0;
      bg_q    <= '0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= bus.req_write_in;
      col_q   <= bus.req_paddr_in[COL_BITS-1:0];
      ba_q    <= bus.req_paddr_in[COL_BITS +: BaW];
      bg_q    <= bus.req_paddr_in[COL_BITS+BaW +: BgW];
      row_q   <= bus.req_paddr_in[COL_BITS+BankW +: ROW_BITS];
      wdata_q <= bus.req_wdata_in;
    end
  end

  // Open-row table follows the commands actually issued.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      open_valid_q <= '0;
      open_row_q   <= '0;
    end else if (cmd_valid && cmd == CmdAct) begin
      open_valid_q[bank_idx] <= 1'b1;
      open_row_q[bank_idx]   <= row_q;
    end else if (cmd_valid && cmd == CmdPre) begin
      open_valid_q[bank_idx] <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StDecide;
      end
      StDecide: begin
        if (hit) begin
          state_d = StXfer;
          cnt_d   = xfer_load;
        end else if (open_valid_q[bank_idx]) begin
          state_d = StWaitPre;
          cnt_d   = PreLoad;
        end else begin
          state_d = StWaitAct;
          cnt_d   = ActLoad;
        end
      end
      StWaitPre: begin
        if (cnt_q == '0) begin
          state_d = StWaitAct;
          cnt_d   = ActLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWaitAct: begin
        if (cnt_q == '0) begin
          state_d = StXfer;
          cnt_d   = xfer_load;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StXfer: begin
        if (cnt_q == '0) begin
          // A request accepted alongside done goes straight to decision.
          state_d = accept ? StDecide : StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd       = CmdNop;
    cmd_valid = 1'b0;
    done      = 1'b0;
    ready     = 1'b0;
    unique case (state_q)
      StIdle: ready = 1'b1;
      StDecide: begin
        cmd_valid = 1'b1;
        if (hit)                         cmd = write_q ? CmdWr : CmdRd;
        else if (open_valid_q[bank_idx]) cmd = CmdPre;
        else                             cmd = CmdAct;
      end
      StWaitPre: begin
        if (cnt_q == '0) begin
          cmd_valid = 1'b1;
          cmd       = CmdAct;
        end
      end
      StWaitAct: begin
        if (cnt_q == '0) begin
          cmd_valid = 1'b1;
          cmd       = write_q ? CmdWr : CmdRd;
        end
      end
      StXfer: begin
        if (cnt_q == '0) begin
          done  = 1'b1;
          ready = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready_out = ready;
  assign bus.cmd_out       = cmd;
  assign bus.cmd_valid_out = cmd_valid;
  assign bus.done_out      = done;
  assign bus.busy_out      = (state_q != StIdle) && !done;
  assign bus.bg_out        = bg_q;
  assign bus.ba_out        = ba_q;
  assign bus.row_out       = row_q;
  assign bus.col_out       = col_q;
  assign bus.wdata_out     = wdata_q;
endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Self-checking bench for bank_cmd_scheduler. A per-bank open-row model predicts, for each
// request, the cycle offsets of PRE/ACT/column command and done, and every cycle of the
// request is compared against that schedule.
module tb_bank_cmd_scheduler;
  localparam int CL = 22;
  localparam int AL = 8;
  localparam int PL = 5;
  localparam int BL = 8;
  localparam int NOP = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bank_cmd_scheduler_if bus ();
  bank_cmd_scheduler dut (.clk_in(clk), .rst_N_in(rst_n), .bus(bus));

  int checks = 0;
  int passes = 0;
  bit       mv[8];
  bit [7:0] mr[8];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_line(output logic [511:0] w);
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd"}, bus.cmd_out, NOP);
    chk({tag, "_cmd_valid"}, bus.cmd_valid_out, 0);
    chk({tag, "_done"}, bus.done_out, 0);
    chk({tag, "_busy"}, bus.busy_out, 0);
    chk({tag, "_ready"}, bus.req_ready_out, 1);
    chk({tag, "_addr"}, {bus.bg_out, bus.ba_out, bus.row_out, bus.col_out}, 0);
    chk({tag, "_wdata"}, bus.wdata_out, 0);
  endtask

  // rst_at >= 0 asserts reset asynchronously in that cycle offset from T0.
  task automatic run_req(input logic wr, input logic [63:0] pa, input int rst_at);
    int bank, row, col, t_pre, t_act, t_col, t_done, exp_cmd;
    logic [511:0] wd, junk;
    bank = int'(pa[6:4]);
    row  = int'(pa[14:7]);
    col  = int'(pa[3:0]);
    t_pre = -1;
    t_act = -1;
    if (mv[bank] && mr[bank] == row[7:0]) begin
      t_col = 0;
    end else if (mv[bank]) begin
      t_pre = 0;
      t_act = PL;
      t_col = PL + AL;
    end else begin
      t_act = 0;
      t_col = AL;
    end
    t_done = t_col + (wr ? BL : CL + BL);
    rand_line(wd);

    chk("ready_before_req", bus.req_ready_out, 1);
    bus.req_valid_in = 1'b1;
    bus.req_write_in = wr;
    bus.req_paddr_in = pa;
    bus.req_wdata_in = wd;
    tick();
    // Scramble request inputs while busy; they must be ignored.
    bus.req_valid_in = 1'b0;
    bus.req_write_in = 1'($urandom);
    bus.req_paddr_in = {$urandom, $urandom};
    rand_line(junk);
    bus.req_wdata_in = junk;

    for (int c = 0; c <= t_done; c++) begin
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        for (int b = 0; b < 8; b++) mv[b] = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("reset_hold_done", bus.done_out, 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
          tick();
          chk("post_reset_no_done", bus.done_out, 0);
          chk("post_reset_no_cmd", bus.cmd_valid_out, 0);
        end
        return;
      end
      if (c == t_pre)      exp_cmd = 3;
      else if (c == t_act) exp_cmd = 2;
      else if (c == t_col) exp_cmd = wr ? 1 : 0;
      else                 exp_cmd = NOP;
      chk($sformatf("cmd@T0+%0d", c), bus.cmd_out, exp_cmd);
      chk($sformatf("cmd_valid@T0+%0d", c), bus.cmd_valid_out, exp_cmd != NOP);
      chk($sformatf("done@T0+%0d", c), bus.done_out, c == t_done);
      chk($sformatf("ready@T0+%0d", c), bus.req_ready_out, c == t_done);
      chk("wdata_stable", bus.wdata_out, wd);
      if (c < t_done) chk("busy_in_flight", bus.busy_out, 1);
      if (exp_cmd != NOP) begin
        chk("cmd_bg", bus.bg_out, pa[6:5]);
        chk("cmd_ba", bus.ba_out, pa[4]);
        if (exp_cmd == 2) chk("act_row", bus.row_out, row);
        if (exp_cmd <= 1) chk("col", bus.col_out, col);
      end
      if (c < t_done) tick();
    end
    mv[bank] = 1'b1;
    mr[bank] = row[7:0];
    tick();
    chk("idle_after_done_busy", bus.busy_out, 0);
    chk("idle_after_done_done", bus.done_out, 0);
    chk("idle_after_done_cmd", bus.cmd_out, NOP);
  endtask

  initial begin
    logic [63:0] pa;
    bus.req_valid_in = 1'b0;
    bus.req_write_in = 1'b0;
    bus.req_paddr_in = '0;
    bus.req_wdata_in = '0;
    rst_n = 1'b0;
    for (int b = 0; b < 8; b++) mv[b] = 1'b0;
    #12;
    check_reset_outputs("in_reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("after_release");

    run_req(1'b0, 64'h0000, -1);  // closed bank
    run_req(1'b0, 64'h0003, -1);  // row hit
    run_req(1'b1, 64'h0080, -1);  // row conflict, write
    run_req(1'b0, 64'h0010, -1);  // other bank closed
    run_req(1'b0, 64'h0081, -1);  // ba0 still open on row1
    run_req(1'b0, 64'h0020, 3);   // reset during activation wait
    run_req(1'b0, 64'h0000, -1);  // table cleared: ACT again

    for (int i = 0; i < 25; i++) begin
      pa = {$urandom, $urandom};
      pa[14:7] = 8'($urandom_range(0, 2));
      pa[6:4]  = 3'($urandom_range(0, 7));
      run_req(1'($urandom), pa, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
